// File: rtl/tcam_loader.sv
// Streams table entries into a TCAM: flushes the array on start, then writes one
// accepted entry per cycle until the last entry arrives or the table overflows.
module tcam_loader #(
    parameter int Bits        = 8,
    parameter int Words       = 16,
    parameter int AddressSize = 4,
    parameter int FlushCycles = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   ent_valid,
    output logic                   ent_ready,
    input  logic [Bits-1:0]        ent_data,
    input  logic [Bits-1:0]        ent_mask,
    input  logic                   ent_last,
    output logic                   CS,
    output logic                   FLUSH,
    output logic                   VBE,
    output logic                   DCS,
    output logic                   WR,
    output logic                   VBI,
    output logic [Bits-1:0]        Data_In,
    output logic [Bits-1:0]        Mask_In,
    output logic [AddressSize-1:0] Addr_In,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [AddressSize:0]   count
);

    localparam int FCW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
    localparam logic [FCW-1:0]       FLUSH_LAST = FCW'(FlushCycles - 1);
    localparam logic [AddressSize:0] LAST_IDX   = (AddressSize + 1)'(Words - 1);
    localparam logic [AddressSize:0] FULL_CNT   = (AddressSize + 1)'(Words);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSHING,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 r_state;
    logic [FCW-1:0]         r_fcnt;
    logic                   r_cs;
    logic                   r_flush;
    logic                   r_wr;
    logic                   r_ent_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [Bits-1:0]        r_data;
    logic [Bits-1:0]        r_mask;
    logic [AddressSize-1:0] r_addr;
    logic [AddressSize:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fcnt      <= '0;
            r_cs        <= 1'b0;
            r_flush     <= 1'b0;
            r_wr        <= 1'b0;
            r_ent_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_data      <= '0;
            r_mask      <= '0;
            r_addr      <= '0;
            r_count     <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them below.
            r_cs    <= 1'b0;
            r_flush <= 1'b0;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        r_state <= S_FLUSHING;
                        r_fcnt  <= '0;
                        r_cs    <= 1'b1;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_count <= '0;
                    end
                end
                S_FLUSHING: begin
                    if (r_fcnt == FLUSH_LAST) begin
                        r_state     <= S_LOAD;
                        r_ent_ready <= 1'b1;
                    end else begin
                        r_fcnt  <= r_fcnt + 1'b1;
                        r_cs    <= 1'b1;
                        r_flush <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (ent_valid) begin
                        r_cs    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_data  <= ent_data;
                        r_mask  <= ent_mask;
                        r_addr  <= r_count[AddressSize-1:0];
                        r_count <= (r_count == FULL_CNT) ? r_count : r_count + 1'b1;
                        // A last flag on the final slot wins over overflow.
                        if (ent_last) begin
                            r_state     <= S_DONE;
                            r_ent_ready <= 1'b0;
                        end else if (r_count == LAST_IDX) begin
                            r_state     <= S_ERR;
                            r_ent_ready <= 1'b0;
                            r_busy      <= 1'b0;
                            r_err       <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ent_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // DCS, VBE and VBI only ever accompany a write.
    assign CS        = r_cs;
    assign FLUSH     = r_flush;
    assign WR        = r_wr;
    assign DCS       = r_wr;
    assign VBE       = r_wr;
    assign VBI       = r_wr;
    assign ent_ready = r_ent_ready;
    assign Data_In   = r_data;
    assign Mask_In   = r_mask;
    assign Addr_In   = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_tcam_loader.sv
// Self-checking bench for tcam_loader: accepted entries are queued as expected
// writes and retired against the TCAM write port on the falling clock edge.
module tb_tcam_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ent_valid;
    logic       ent_ready;
    logic [7:0] ent_data;
    logic [7:0] ent_mask;
    logic       ent_last;
    logic       CS, FLUSH, VBE, DCS, WR, VBI;
    logic [7:0] Data_In, Mask_In;
    logic [3:0] Addr_In;
    logic       busy, done, err;
    logic [4:0] count;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
        bit         last;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_cnt = 0;
    bit   exp_done = 1'b0;
    int   fcnt = 0;

    tcam_loader #(
        .Bits(8), .Words(16), .AddressSize(4), .FlushCycles(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ent_valid(ent_valid), .ent_ready(ent_ready),
        .ent_data(ent_data), .ent_mask(ent_mask), .ent_last(ent_last),
        .CS(CS), .FLUSH(FLUSH), .VBE(VBE), .DCS(DCS), .WR(WR), .VBI(VBI),
        .Data_In(Data_In), .Mask_In(Mask_In), .Addr_In(Addr_In),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write-port monitor: retires expected writes and tracks done and FLUSH length.
    always @(negedge clk) begin
        bit nxt_done;
        exp_t e;
        nxt_done = 1'b0;
        if (!rst_n) begin
            exp_done = 1'b0;
            fcnt     = 0;
        end else begin
            check("done", done, exp_done);
            if (WR) begin
                if (sb.size() == 0) begin
                    check("wr_unexpected", WR, 0);
                end else begin
                    e = sb.pop_front();
                    check("wr_strobes", {CS, DCS, VBE, VBI, FLUSH}, 5'b11110);
                    check("wr_addr", Addr_In, e.addr);
                    check("wr_data", Data_In, e.data);
                    check("wr_mask", Mask_In, e.mask);
                    nxt_done = e.last;
                end
            end else begin
                check("nowr_strobes", {DCS, VBE, VBI}, 3'b000);
                check("cs_eq_flush", CS, FLUSH);
            end
            exp_done = nxt_done;
            if (FLUSH) begin
                fcnt++;
            end else if (fcnt != 0) begin
                check("flush_len", fcnt, 2);
                fcnt = 0;
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_cnt = 0;
        check("start_flush", FLUSH, 1);
        check("start_busy", busy, 1);
        check("start_count", count, 0);
        check("start_err", err, 0);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_entry(input logic [7:0] d, input logic [7:0] m, input bit last);
        int guard;
        exp_t e;
        guard = 0;
        ent_valid = 1'b1;
        ent_data  = d;
        ent_mask  = m;
        ent_last  = last;
        while (!ent_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ent_ready) begin
            check("ready_timeout", ent_ready, 1);
        end else begin
            e.addr = 4'(model_cnt);
            e.data = d;
            e.mask = m;
            e.last = last;
            sb.push_back(e);
            model_cnt++;
            @(posedge clk); #1;
        end
        ent_valid = 1'b0;
        ent_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        ent_valid = 1'b0;
        ent_data = '0;
        ent_mask = '0;
        ent_last = 1'b0;
        #1 rst_n = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_ctrl", {CS, FLUSH, VBE, DCS, WR, VBI, ent_ready, busy, done, err}, 0);
        check("rst_data", {Data_In, Mask_In, Addr_In, count}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold", {busy, FLUSH, ent_ready}, 0);

        // Basic load of three entries
        do_start();
        send_entry(8'h11, 8'hFF, 0);
        send_entry(8'h22, 8'hFF, 0);
        send_entry(8'h33, 8'hFF, 1);
        check("basic_wr_last", WR, 1);
        check("basic_busy_done_state", busy, 1);
        check("basic_ready_off", ent_ready, 0);
        @(posedge clk); #1;
        check("basic_done", done, 1);
        check("basic_busy_off", busy, 0);
        check("basic_count", count, 3);
        drain("basic_drain");
        check("basic_count_hold", count, 3);

        // Gapped stream: valid 1,0,1
        do_start();
        send_entry(8'hA5, 8'h0F, 0);
        @(posedge clk); #1;
        check("gap_nowr", WR, 0);
        check("gap_addr_hold", Addr_In, 0);
        send_entry(8'h5A, 8'hF0, 1);
        check("gap_addr", Addr_In, 1);
        drain("gap_drain");
        check("gap_count", count, 2);

        // Start pulsed during LOAD is ignored
        do_start();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) start = 1'b1;
            send_entry(8'(8'h40 + i), 8'(8'hC0 | i), i == 3);
            start = 1'b0;
        end
        drain("busy_start_drain");
        check("busy_start_count", count, 4);

        // Full table with last on the 16th entry
        do_start();
        for (int i = 0; i < 16; i++) begin
            send_entry(8'(i * 17 + 3), 8'(~i), i == 15);
        end
        check("full_err", err, 0);
        check("full_busy", busy, 1);
        drain("full_drain");
        check("full_count", count, 16);
        check("full_err_after", err, 0);

        // Overflow: 16 entries without last
        do_start();
        for (int i = 0; i < 16; i++) begin
            send_entry(8'(i * 5 + 1), 8'(i), 0);
        end
        check("ovf_last_wr", WR, 1);
        check("ovf_err", err, 1);
        check("ovf_ready", ent_ready, 0);
        check("ovf_busy", busy, 0);
        check("ovf_count", count, 16);
        ent_valid = 1'b1;
        ent_data = 8'hEE;
        repeat (5) @(posedge clk);
        #1;
        ent_valid = 1'b0;
        check("ovf_err_sticky", err, 1);
        check("ovf_count_hold", count, 16);
        check("ovf_drain", sb.size(), 0);
        do_start();
        send_entry(8'h77, 8'h3C, 1);
        drain("ovf_recover_drain");
        check("ovf_recover_count", count, 1);

        // Reset asserted during the second write
        do_start();
        send_entry(8'hA1, 8'h0F, 0);
        ent_valid = 1'b1;
        ent_data = 8'hA2;
        ent_mask = 8'hF0;
        @(posedge clk);
        #2 check("rst_mid_wr2", WR, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {CS, FLUSH, VBE, DCS, WR, VBI, ent_ready, busy, done, err}, 0);
        check("rst_mid_data", {Data_In, Mask_In, Addr_In, count}, 0);
        ent_valid = 1'b0;
        sb.delete();
        model_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_post_idle", {busy, ent_ready, FLUSH, done, WR}, 0);
        do_start();
        send_entry(8'h5A, 8'hC3, 1);
        drain("rst_recover_drain");
        check("rst_recover_count", count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tcam_loader.md
TCAM_LOADER -- requirements
Module: tcam_loader

Interface
REQ-001 The module SHALL take parameter Bits, default 8, as the TCAM entry data/mask width.
REQ-002 The module SHALL take parameter Words, default 16, as the number of TCAM entries.
REQ-003 The module SHALL take parameter AddressSize, default 4, as the TCAM address width.
REQ-004 The module SHALL take parameter FlushCycles, default 2, as the number of cycles FLUSH is held.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port start, input, 1 bit: request to flush and reload the table.
REQ-008 Port ent_valid, input, 1 bit: the entry stream carries a valid entry.
REQ-009 Port ent_ready, output, 1 bit: the loader accepts an entry this cycle.
REQ-010 Port ent_data, input, Bits: entry data word.
REQ-011 Port ent_mask, input, Bits: entry mask word.
REQ-012 Port ent_last, input, 1 bit: marks the final entry of the stream.
REQ-013 Ports CS, FLUSH, VBE, DCS, WR, VBI, output, 1 bit each: TCAM control strobes.
REQ-014 Ports Data_In and Mask_In, output, Bits each: TCAM write data and mask.
REQ-015 Port Addr_In, output, AddressSize: TCAM write address.
REQ-016 Port busy, output, 1 bit: a load is in progress.
REQ-017 Port done, output, 1 bit: one-cycle load-complete pulse.
REQ-018 Port err, output, 1 bit: sticky overflow flag.
REQ-019 Port count, output, AddressSize+1: number of entries written in the current load.

Function
REQ-020 The FSM SHALL have the states IDLE, FLUSHING, LOAD, DONE and ERR, and all outputs SHALL be registered.
REQ-021 In IDLE, start=1 SHALL go to FLUSHING and clear count and err; in any other state except ERR, start SHALL be ignored.
REQ-022 FLUSHING SHALL drive FLUSH=1 and CS=1 for exactly FlushCycles cycles, then go to LOAD.
REQ-023 In LOAD, ent_ready SHALL be 1, and ent_ready SHALL be 0 in every other state.
REQ-024 An accepted entry (ent_valid & ent_ready) at cycle t SHALL produce, at t+1, WR=CS=DCS=VBE=VBI=1, Data_In=ent_data, Mask_In=ent_mask and Addr_In=count(t)[AddressSize-1:0]; count SHALL increment at t+1.
REQ-025 Entries SHALL be accepted back-to-back, one per cycle, with no bubble.
REQ-026 In cycles with no write, WR, DCS, VBE and VBI SHALL be 0; CS SHALL be 1 only during FLUSH or write cycles.
REQ-027 When an entry is accepted with ent_last=1, the FSM SHALL go to DONE, so that DONE coincides with the final WR cycle.
REQ-028 DONE SHALL last one cycle, then go to IDLE with done=1 for exactly that next cycle.
REQ-029 Latency SHALL be: accept of the last entry at cycle t gives its WR at t+1 and done at t+2.
REQ-030 When the Words-th entry is accepted with ent_last=0, that entry SHALL still be written, then the FSM SHALL go to ERR with err=1.
REQ-031 In ERR, ent_ready SHALL be 0 and no writes SHALL occur; err SHALL hold until start=1, which SHALL go to FLUSHING and clear err.
REQ-032 If ent_last=1 arrives on the Words-th entry, the load SHALL be a normal DONE with no error.
REQ-033 A zero-entry stream SHALL NOT occur; the FSM SHALL remain in LOAD until it accepts an entry with ent_last=1.
REQ-034 busy SHALL be 1 in FLUSHING, LOAD and DONE, and 0 otherwise.
REQ-035 count SHALL saturate at Words and SHALL hold its value after DONE until the next start.

Reset
REQ-036 While rst_n=0, asynchronously: the state SHALL be IDLE; all strobes, ent_ready, busy, done and err SHALL be 0; Data_In, Mask_In, Addr_In and count SHALL be 0.
REQ-037 Reset asserted mid-load SHALL abort the load immediately, and WR SHALL fall without waiting for a clock edge.
REQ-038 After reset release, the FSM SHALL remain in IDLE until start is asserted.

Verification
REQ-039 Basic load: start, then 3 entries (data 0x11/0x22/0x33, mask 0xFF, last on the 3rd) -> FLUSH high for 2 cycles; WR at Addr 0,1,2 on consecutive cycles; done 2 cycles after the 3rd accept; count=3.
REQ-040 Gapped stream: ent_valid toggling 1,0,1 -> WR only in the cycles after accepts; Addr_In increments only on writes.
REQ-041 Full table: 16 entries with last on the 16th -> Addr 0..15 written; done=1; err=0; count=16.
REQ-042 Overflow: 16 entries with no last -> 16 writes, then err=1, ent_ready=0, no further WR; a later start clears err and re-flushes.
REQ-043 Reset mid-load: rst_n low during the 2nd WR -> all outputs 0 asynchronously; state IDLE after release; no done pulse.
REQ-044 Start while busy: pulse start during LOAD -> ignored; addressing and count continue undisturbed.
